// File: rtl/lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_master
// Purpose  : Load/store unit, initiator side of the word-addressed DMEM port.
//            Byte/half stores are done as a read-modify-write.
// Options  : LSU_RANGE_CHECK_EN - flag word indices >= MEM_WORDS as errors
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem_master #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_store;
    logic [31:0] r_merge;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_range_err;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic [31:0] w_word_addr;

    // Request classification, evaluated on the live request at accept time.
    assign w_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                          (req_store && req_funct3[2]);
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);
    assign w_range_err  = (req_addr[31:2] >= c_mem_words);
`else
    assign w_range_err  = 1'b0;
`endif
    assign w_req_err    = w_illegal || w_misaligned || w_range_err;

    assign w_word_addr  = {r_addr[31:2], 2'b00};

    // Little-endian lane selection and sign/zero extension for loads.
    always_comb begin
        w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (r_addr[1:0])
            2'b00:   w_byte = mem_read_data[7:0];
            2'b01:   w_byte = mem_read_data[15:8];
            2'b10:   w_byte = mem_read_data[23:16];
            default: w_byte = mem_read_data[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = mem_read_data;
        endcase
    end

    // Merge the store lane into the word read back from DMEM.
    always_comb begin
        w_merged = mem_read_data;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merged[7:0]   = r_wdata[7:0];
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0]  = r_wdata[15:0];
        end
    end

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and DMEM/handshake outputs.
    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    if (w_req_err)                 w_state_next = S_RESP;
                    else if (!req_store)           w_state_next = S_LOAD;
                    else if (req_funct3 == 3'b010) w_state_next = S_WRITE;
                    else                           w_state_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_address  = w_word_addr;
                w_state_next = S_RESP;
            end
            S_RMW_RD: begin
                mem_address  = w_word_addr;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                // Reset gates the strobe combinationally so an aborted RMW never writes.
                mem_write      = r_store && !rst;
                mem_address    = w_word_addr;
                mem_write_data = r_merge;
                w_state_next   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request latches, merge register and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= 32'h0;
            r_funct3   <= 3'h0;
            r_wdata    <= 32'h0;
            r_store    <= 1'b0;
            r_merge    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_funct3   <= req_funct3;
                        r_wdata    <= req_wdata;
                        r_store    <= req_store;
                        r_merge    <= req_wdata;
                        resp_rdata <= 32'h0;
                        resp_err   <= w_req_err;
                    end
                end
                S_LOAD:   resp_rdata <= w_load_data;
                S_RMW_RD: r_merge    <= w_merged;
                S_RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_master
// Purpose  : Directed bench for lsu_dmem_master with a behavioural DMEM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_dmem_master #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Behavioural DMEM: 256 words, combinational read, 0 outside the array.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_write && (mem_address[31:10] == 22'h0)) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
    end
    assign mem_read_data = (mem_address[31:10] == 22'h0) ? mem[mem_address[9:2]] : 32'h0;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_writes;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee,
                                input int lat, input int nw, input logic [31:0] wa,
                                input logic [31:0] wv);
        vec_t v;
        v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_writes = nw;
        v.exp_waddr = wa; v.exp_wdata = wv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction: offer, track DMEM activity, check response, consume.
    task automatic run_vec(input vec_t v, input int idx);
        int guard;
        int lat;
        int writes;
        logic [31:0] wa, wv;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; writes = 0; wa = 32'h0; wv = 32'h0;
        while (!resp_valid && lat < 10) begin
            if (mem_write) begin
                writes++;
                wa = mem_address;
                wv = mem_write_data;
            end
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), {31'h0, resp_err}, {31'h0, v.exp_err});
        check($sformatf("v%0d_writes", idx), writes, v.exp_writes);
        check($sformatf("v%0d_busy", idx), {31'h0, req_ready}, 32'h0);
        if (v.exp_writes > 0) begin
            check($sformatf("v%0d_waddr", idx), wa, v.exp_waddr);
            check($sformatf("v%0d_wdata", idx), wv, v.exp_wdata);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check($sformatf("v%0d_consumed", idx), {30'h0, resp_valid, resp_err}, 32'h0);
        check($sformatf("v%0d_cleared", idx), resp_rdata, 32'h0);
    endtask

    vec_t vecs [0:15];

    initial begin
        logic [31:0] held;
        vecs[0]  = mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h10, 32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2, 0, 0, 0);
        vecs[2]  = mk(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 2, 0, 0, 0);
        vecs[3]  = mk(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, 2, 0, 0, 0);
        vecs[4]  = mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2, 0, 0, 0);
        vecs[5]  = mk(1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 0, 3, 1, 32'h10, 32'hDEAD55EF);
        vecs[6]  = mk(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, 0, 0, 0);
        vecs[7]  = mk(1, 3'b001, 32'h12, 32'hABCD1234, 32'h0, 0, 3, 1, 32'h10, 32'h123455EF);
        vecs[8]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 2, 0, 0, 0);
        vecs[9]  = mk(0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        vecs[10] = mk(1, 3'b001, 32'h03, 32'h1111, 32'h0, 1, 1, 0, 0, 0);
        vecs[11] = mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        vecs[12] = mk(1, 3'b100, 32'h10, 32'h77, 32'h0, 1, 1, 0, 0, 0);
        vecs[13] = mk(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 2, 0, 0, 0);
`ifdef LSU_RANGE_CHECK_EN
        vecs[14] = mk(0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        vecs[15] = mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0, 0);
`else
        vecs[14] = mk(0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 2, 0, 0, 0);
        vecs[15] = mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'h400, 32'hCAFEF00D);
`endif

        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready_low", {31'h0, req_ready}, 32'h0);
        mem_clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_mem_ctl", {31'h0, mem_write}, 32'h0);
        check("reset_mem_addr", mem_address, 32'h0);
        check("reset_mem_wdata", mem_write_data, 32'h0);
        check("reset_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Stalled consumer: response must hold and a busy-time request is ignored.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_store = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("hold_first_valid", {31'h0, resp_valid}, 32'h1);
        held = resp_rdata;
        check("hold_first_rdata", held, 32'h123455EF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), {31'h0, resp_valid}, 32'h1);
            check($sformatf("hold%0d_rdata", k), resp_rdata, 32'h123455EF);
            check($sformatf("hold%0d_ready", k), {31'h0, req_ready}, 32'h0);
            check($sformatf("hold%0d_nowrite", k), {31'h0, mem_write}, 32'h0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("hold_released", {31'h0, resp_valid}, 32'h0);
        check("busy_req_ignored", mem[8], 32'h0);

        // Reset while the RMW write is on the bus: no write may reach memory.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_nowrite", {31'h0, mem_write}, 32'h0);
        check("rmw_rd_addr", mem_address, 32'h10);
        @(negedge clk);
        check("rmw_wr_strobe", {31'h0, mem_write}, 32'h1);
        check("rmw_wr_data", mem_write_data, 32'h123455AA);
        rst = 1'b1;
        #1;
        check("rst_gates_write", {31'h0, mem_write}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_abort_idle", {31'h0, req_ready}, 32'h1);
        check("rst_abort_noresp", {31'h0, resp_valid}, 32'h0);
        check("rst_abort_mem", mem[4], 32'h123455EF);
        run_vec(mk(0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0, 2, 0, 0, 0), 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
